// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register pending/countdown/age scoreboard for ID-stage stall and forwarding
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int NFWD     = 2,
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic [$clog2(NREG)-1:0]     id_rs1,
    input  logic [$clog2(NREG)-1:0]     id_rs2,
    input  logic                        id_rs1_used,
    input  logic                        id_rs2_used,
    input  logic [$clog2(NREG)-1:0]     id_rd,
    input  logic                        id_rd_we,
    input  logic [1:0]                  id_class,
    input  logic                        flush,
    input  logic                        hold,
    output logic                        stall,
    output logic                        issue,
    output logic [$clog2(NFWD+1)-1:0]   fwd_rs1,
    output logic [$clog2(NFWD+1)-1:0]   fwd_rs2,
    output logic [NREG-1:0]             busy_mask,
    output logic [15:0]                 stall_cycles
);

    localparam int RW = $clog2(NREG);
    localparam int FW = $clog2(NFWD + 1);
    localparam logic [FW-1:0] AGE_LAST = FW'(NFWD);

    localparam logic [1:0] CLASS_LOAD = 2'd1;
    localparam logic [1:0] CLASS_MUL  = 2'd2;

    logic [NREG-1:0] pend_q, pend_d;
    logic [FW-1:0]   cnt_q [NREG];
    logic [FW-1:0]   cnt_d [NREG];
    logic [FW-1:0]   age_q [NREG];
    logic [FW-1:0]   age_d [NREG];
    logic [15:0]     stall_cycles_q, stall_cycles_d;

    logic            haz_rs1, haz_rs2;
    logic            rdy_rs1, rdy_rs2;
    logic [FW-1:0]   lat_m1;

    // A pending source is either still counting down (hazard) or forwardable from its stage.
    always_comb begin
        haz_rs1 = 1'b0;
        haz_rs2 = 1'b0;
        rdy_rs1 = 1'b0;
        rdy_rs2 = 1'b0;
        if (id_rs1_used && (id_rs1 != '0) && pend_q[id_rs1]) begin
            haz_rs1 = (cnt_q[id_rs1] != '0);
            rdy_rs1 = (cnt_q[id_rs1] == '0);
        end
        if (id_rs2_used && (id_rs2 != '0) && pend_q[id_rs2]) begin
            haz_rs2 = (cnt_q[id_rs2] != '0);
            rdy_rs2 = (cnt_q[id_rs2] == '0);
        end
    end

    assign stall     = id_valid && !flush && (haz_rs1 || haz_rs2);
    assign issue     = id_valid && !flush && !hold && !stall;
    assign fwd_rs1   = rdy_rs1 ? age_q[id_rs1] : '0;
    assign fwd_rs2   = rdy_rs2 ? age_q[id_rs2] : '0;
    assign busy_mask = {pend_q[NREG-1:1], 1'b0};
    assign stall_cycles = stall_cycles_q;

    always_comb begin
        case (id_class)
            CLASS_LOAD: lat_m1 = FW'(LOAD_LAT);
            CLASS_MUL:  lat_m1 = FW'(MUL_LAT - 1);
            default:    lat_m1 = '0;
        endcase
    end

    always_comb begin
        pend_d         = pend_q;
        cnt_d          = cnt_q;
        age_d          = age_q;
        stall_cycles_d = stall_cycles_q;
        if (!hold) begin
            for (int r = 1; r < NREG; r++) begin
                if (pend_q[r]) begin
                    if (age_q[r] == AGE_LAST) begin
                        pend_d[r] = 1'b0;
                        cnt_d[r]  = '0;
                        age_d[r]  = '0;
                    end else begin
                        age_d[r] = age_q[r] + FW'(1);
                        cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - FW'(1) : '0;
                    end
                end
            end
            // Applied last so a new writer overrides both ageing and same-edge retirement.
            if (issue && id_rd_we && (id_rd != RW'(0))) begin
                pend_d[id_rd] = 1'b1;
                cnt_d[id_rd]  = lat_m1;
                age_d[id_rd]  = FW'(1);
            end
            if (stall && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_d = stall_cycles_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q         <= '0;
            cnt_q          <= '{default: '0};
            age_q          <= '{default: '0};
            stall_cycles_q <= '0;
        end else begin
            pend_q         <= pend_d;
            cnt_q          <= cnt_d;
            age_q          <= age_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule
